// File: rtl/tlk2711_run_ctrl.sv
// Run sequencer for the TLK2711 transmit datapath: start/stop command intake,
// link start pulse, stop/stop-ack handshake with timeout, and post-stop settle gap.
module tlk2711_run_ctrl #(
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned STOP_TIMEOUT  = 1024,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [1:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_len,
    output logic             o_start,
    output logic [1:0]       o_mode,
    output logic             o_stop,
    input  logic             i_stop_ack,
    input  logic             err_clr,
    output logic             o_timeout_err,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_run_cnt,
    output logic [2:0]       o_state
);

    // One timer serves both the stop-ack wait and the settle gap.
    localparam int unsigned TMR_MAX = (STOP_TIMEOUT > SETTLE_CYCLES) ? STOP_TIMEOUT : SETTLE_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;
    localparam logic [TMR_W-1:0] TMO_LAST    = TMR_W'(STOP_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_RUN       = 3'd2,
        ST_STOP_WAIT = 3'd3,
        ST_SETTLE    = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TMR_W-1:0]   r_tmr;
    logic [TMR_W-1:0]   w_tmr_nxt;
    logic [CNT_W-1:0]   r_len;
    logic [CNT_W-1:0]   w_len_nxt;
    logic [CNT_W-1:0]   r_run_cnt;
    logic [CNT_W-1:0]   w_run_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [1:0]         r_mode;
    logic [1:0]         w_mode_nxt;
    logic               r_err;
    logic               w_err_set;
    logic               w_err_nxt;
    logic               r_start;
    logic               r_stop;
    logic               r_busy;
    logic               w_cmd_ready;
    logic               w_start_cmd;
    logic               w_stop_cmd;

    // Command handshake: only IDLE and RUN consume commands; others hold them off.
    always_comb begin
        w_cmd_ready = (r_state == ST_IDLE) || (r_state == ST_RUN);
        w_start_cmd = cmd_valid && w_cmd_ready && !cmd_op;
        w_stop_cmd  = cmd_valid && w_cmd_ready && cmd_op;
        w_cnt_inc   = (r_run_cnt == CNT_MAX) ? r_run_cnt : r_run_cnt + CNT_W'(1);
    end

    // Next-state, timer, run counter and latched-command logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_tmr_nxt     = '0;
        w_len_nxt     = r_len;
        w_run_cnt_nxt = r_run_cnt;
        w_mode_nxt    = r_mode;
        w_err_set     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_cmd) begin
                    w_state_nxt   = ST_START;
                    w_mode_nxt    = cmd_mode;
                    w_len_nxt     = cmd_len;
                    w_run_cnt_nxt = '0;
                end
            end
            ST_START: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_run_cnt_nxt = w_cnt_inc;
                if (w_stop_cmd || ((r_len != '0) && (w_cnt_inc == r_len))) begin
                    w_state_nxt = ST_STOP_WAIT;
                end
            end
            ST_STOP_WAIT: begin
                if (i_stop_ack) begin
                    w_state_nxt = ST_SETTLE;
                end else if (r_tmr == TMO_LAST) begin
                    w_state_nxt = ST_SETTLE;
                    w_err_set   = 1'b1;
                end else begin
                    w_tmr_nxt = r_tmr + TMR_W'(1);
                end
            end
            ST_SETTLE: begin
                if (r_tmr == SETTLE_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tmr_nxt = r_tmr + TMR_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // A new timeout wins over a simultaneous clear.
        w_err_nxt = w_err_set ? 1'b1 : (err_clr ? 1'b0 : r_err);
    end

    // State and registered outputs; link controls decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_tmr     <= '0;
            r_len     <= '0;
            r_run_cnt <= '0;
            r_mode    <= 2'd0;
            r_err     <= 1'b0;
            r_start   <= 1'b0;
            r_stop    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tmr     <= w_tmr_nxt;
            r_len     <= w_len_nxt;
            r_run_cnt <= w_run_cnt_nxt;
            r_mode    <= w_mode_nxt;
            r_err     <= w_err_nxt;
            r_start   <= (w_state_nxt == ST_START);
            r_stop    <= (w_state_nxt == ST_STOP_WAIT);
            r_busy    <= (w_state_nxt != ST_IDLE);
        end
    end

    assign cmd_ready     = w_cmd_ready;
    assign o_start       = r_start;
    assign o_mode        = r_mode;
    assign o_stop        = r_stop;
    assign o_timeout_err = r_err;
    assign o_busy        = r_busy;
    assign o_run_cnt     = r_run_cnt;
    assign o_state       = r_state;

endmodule

// File: tb/tb_tlk2711_run_ctrl.sv
// Bench for tlk2711_run_ctrl: each run is described by its phase lengths
// (START, RUN, STOP_WAIT, SETTLE) derived arithmetically from the command,
// and every cycle's outputs are compared against that timeline.
module tb_tlk2711_run_ctrl;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned TO    = 1024;
    localparam int unsigned SC    = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_op;
    logic [1:0]       cmd_mode;
    logic [CNT_W-1:0] cmd_len;
    logic             o_start;
    logic [1:0]       o_mode;
    logic             o_stop;
    logic             i_stop_ack;
    logic             err_clr;
    logic             o_timeout_err;
    logic             o_busy;
    logic [CNT_W-1:0] o_run_cnt;
    logic [2:0]       o_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [1:0]       exp_mode;
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_err;

    tlk2711_run_ctrl #(
        .CNT_W(CNT_W), .STOP_TIMEOUT(TO), .SETTLE_CYCLES(SC)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_mode(cmd_mode), .cmd_len(cmd_len),
        .o_start(o_start), .o_mode(o_mode), .o_stop(o_stop),
        .i_stop_ack(i_stop_ack), .err_clr(err_clr),
        .o_timeout_err(o_timeout_err), .o_busy(o_busy),
        .o_run_cnt(o_run_cnt), .o_state(o_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_all(input string ph, input logic [2:0] st, input logic e_start,
                           input logic e_stop, input logic rdy);
        chk({ph, ".state"},   64'(o_state),       64'(st));
        chk({ph, ".start"},   64'(o_start),       64'(e_start));
        chk({ph, ".stop"},    64'(o_stop),        64'(e_stop));
        chk({ph, ".busy"},    64'(o_busy),        64'(st != 3'd0));
        chk({ph, ".ready"},   64'(cmd_ready),     64'(rdy));
        chk({ph, ".mode"},    64'(o_mode),        64'(exp_mode));
        chk({ph, ".run_cnt"}, 64'(o_run_cnt),     64'(exp_cnt));
        chk({ph, ".err"},     64'(o_timeout_err), 64'(exp_err));
    endtask

    // Idle cycles, optionally presenting a stop command and/or pulsing err_clr first.
    task automatic idle_cycles(input int n, input bit clr, input bit stop_cmd);
        for (int k = 0; k < n; k++) begin
            cmd_valid  = stop_cmd;
            cmd_op     = 1'b1;
            cmd_mode   = 2'($urandom);
            cmd_len    = CNT_W'($urandom);
            err_clr    = clr && (k == 0);
            i_stop_ack = 1'($urandom);
            sample();
            chk_all("idle", 3'd0, 1'b0, 1'b0, 1'b1);
            if (err_clr) exp_err = 1'b0;
            tick();
        end
    endtask

    // One complete run starting from an IDLE cycle.
    // stop_at: RUN cycle (1-based) carrying a stop cmd, 0 = none.
    // ack_at : STOP_WAIT cycle (1-based) carrying the ack, 0 = never.
    // sir    : RUN cycle carrying a (to-be-ignored) start cmd, 0 = none.
    // clr_j  : STOP_WAIT cycle carrying err_clr, 0 = none.
    // hold   : present the next start cmd throughout STOP_WAIT and SETTLE.
    task automatic run_one(input logic [1:0] mode, input logic [CNT_W-1:0] len,
                           input int stop_at, input int ack_at, input int sir,
                           input int clr_j, input bit hold, input logic [1:0] nmode,
                           input logic [CNT_W-1:0] nlen, input bit rnd_ack);
        int         r_len;
        int         w_len;
        int         i;
        int         j;
        bit         tmo;
        string      ph;
        logic [2:0] st;
        logic       rdy;
        if (len == '0)                                         r_len = stop_at;
        else if (stop_at != 0 && CNT_W'(stop_at) < len)        r_len = stop_at;
        else                                                   r_len = int'(len);
        tmo   = (ack_at == 0) || (ack_at > int'(TO));
        w_len = tmo ? int'(TO) : ack_at;
        for (int k = 0; k <= 1 + r_len + w_len + int'(SC); k++) begin
            cmd_valid  = 1'b0;
            cmd_op     = 1'b0;
            cmd_mode   = 2'($urandom);
            cmd_len    = CNT_W'($urandom);
            err_clr    = 1'b0;
            i_stop_ack = rnd_ack ? 1'($urandom) : 1'b0;
            i = 0;
            j = 0;
            if (k == 0) begin
                ph = "idle_acc"; st = 3'd0; rdy = 1'b1;
                cmd_valid = 1'b1; cmd_op = 1'b0; cmd_mode = mode; cmd_len = len;
            end else if (k == 1) begin
                ph = "start"; st = 3'd1; rdy = 1'b0;
                exp_mode = mode;
                exp_cnt  = '0;
            end else if (k <= 1 + r_len) begin
                ph = "run"; st = 3'd2; rdy = 1'b1;
                i = k - 1;
                exp_cnt = CNT_W'(i - 1);
                if (i == stop_at) begin
                    cmd_valid = 1'b1; cmd_op = 1'b1;
                end else if (i == sir) begin
                    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_mode = ~mode;
                end
            end else begin
                exp_cnt = CNT_W'(r_len);
                rdy = 1'b0;
                if (k <= 1 + r_len + w_len) begin
                    ph = "stop_wait"; st = 3'd3;
                    j = k - 1 - r_len;
                    i_stop_ack = (j == ack_at);
                    err_clr    = (j == clr_j);
                end else begin
                    ph = "settle"; st = 3'd4;
                end
                if (hold) begin
                    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_mode = nmode; cmd_len = nlen;
                end
            end
            sample();
            chk_all(ph, st, k == 1, st == 3'd3, rdy);
            if (st == 3'd3 && tmo && j == w_len) exp_err = 1'b1;
            else if (err_clr)                    exp_err = 1'b0;
            tick();
        end
    endtask

    initial begin
        logic [1:0] m;
        int         l;
        int         s;
        int         a;
        int         r;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_mode = 2'd0; cmd_len = '0;
        i_stop_ack = 1'b0; err_clr = 1'b0;
        exp_mode = 2'd0; exp_cnt = '0; exp_err = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        sample();
        chk_all("reset", 3'd0, 1'b0, 1'b0, 1'b1);
        tick();

        // Stop commands in IDLE are consumed with no effect.
        idle_cycles(3, 1'b0, 1'b1);
        // Timed run, mode 2, length 5, ack in third STOP_WAIT cycle.
        run_one(2'd2, 5, 0, 3, 0, 0, 1'b0, 2'd0, '0, 1'b0);
        // Continuous run stopped on RUN cycle 100.
        run_one(2'd1, 0, 100, 4, 0, 0, 1'b0, 2'd0, '0, 1'b0);
        // Never acked: timeout sets the sticky error.
        run_one(2'd3, 4, 0, 0, 0, 0, 1'b0, 2'd0, '0, 1'b0);
        idle_cycles(2, 1'b1, 1'b0);
        // Clear on the same cycle as a new timeout: set wins.
        run_one(2'd0, 4, 0, 0, 0, int'(TO), 1'b0, 2'd0, '0, 1'b0);
        idle_cycles(2, 1'b1, 1'b0);
        // Ack on the exact timeout cycle: no error.
        run_one(2'd2, 3, 0, int'(TO), 0, 0, 1'b0, 2'd0, '0, 1'b0);
        // Start command during RUN is consumed and ignored.
        run_one(2'd1, 6, 0, 2, 3, 0, 1'b0, 2'd0, '0, 1'b0);
        // Stop on the same cycle the length expires.
        run_one(2'd2, 6, 6, 1, 0, 0, 1'b0, 2'd0, '0, 1'b0);
        // Start held through STOP_WAIT/SETTLE, accepted on return to IDLE.
        run_one(2'd3, 2, 0, 5, 0, 0, 1'b1, 2'd1, 3, 1'b0);
        run_one(2'd1, 3, 0, 2, 0, 0, 1'b0, 2'd0, '0, 1'b0);

        // Randomized runs with stray acks outside STOP_WAIT.
        for (int n = 0; n < 20; n++) begin
            m = 2'($urandom);
            l = int'($urandom_range(0, 20));
            if (l == 0) s = int'($urandom_range(1, 40));
            else        s = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, l + 2)) : 0;
            a = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 30));
            r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0;
            if (r == s) r = 0;
            run_one(m, CNT_W'(l), s, a, r, 0, 1'b0, 2'd0, '0, 1'b1);
        end

        // Reset while in STOP_WAIT with o_stop asserted.
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_mode = 2'd2; cmd_len = 2; i_stop_ack = 1'b0;
        tick();
        cmd_valid = 1'b0;
        repeat (4) tick();
        sample();
        chk("pre_rst.stop", 64'(o_stop), 64'(1'b1));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_mode = 2'd0; exp_cnt = '0; exp_err = 1'b0;
        sample();
        chk_all("post_rst", 3'd0, 1'b0, 1'b0, 1'b1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tlk2711_run_ctrl.md
Name: tlk2711_run_ctrl

Overview:
Run sequencer for the TLK2711 transmit datapath, clocked on the 80 MHz link clock. Accepts start/stop commands from the MPSoC register side and drives the link's start pulse, mode select and stop request. Performs the stop/stop-acknowledge handshake with a timeout, then enforces a settle gap before the next run. Supports timed runs of a programmed cycle count or continuous runs terminated by a stop command.

Parameters:
CNT_W, 32, width of run length and run counter
STOP_TIMEOUT, 1024, max cycles to wait for stop ack (>=2)
SETTLE_CYCLES, 16, idle gap after stop completes (>=1)

Ports:
clk  in  1  link clock (80 MHz)
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  1  0=start, 1=stop
cmd_mode  in  2  link mode for a start command
cmd_len  in  CNT_W  run length in cycles; 0=continuous
o_start  out  1  one-cycle start pulse to link
o_mode  out  2  latched mode, held for whole run
o_stop  out  1  stop request level to link
i_stop_ack  in  1  stop acknowledge from link
err_clr  in  1  clears o_timeout_err
o_timeout_err  out  1  sticky: stop ack timed out
o_busy  out  1  state != IDLE
o_run_cnt  out  CNT_W  RUN cycles of current/last run
o_state  out  3  IDLE=0 START=1 RUN=2 STOP_WAIT=3 SETTLE=4

Behaviour:
- One clock domain, clk; reset is synchronous and active-high (rst). All state changes on rising clk.
- Reset (any state, including mid-run or mid-handshake): state IDLE next cycle.
  - o_start=0, o_stop=0, o_mode=0, o_run_cnt=0, o_timeout_err=0, o_busy=0.
  - cmd_ready=1 from the first cycle after reset.
- cmd_ready = (state==IDLE) | (state==RUN), combinational from state. Commands presented in other states are held off, not dropped.
- IDLE:
  - Accepted start: latch cmd_mode into o_mode and cmd_len internally; clear o_run_cnt; go to START.
  - Accepted stop: consumed, no effect.
- START (exactly 1 cycle): o_start=1; next state RUN. o_start is 0 in every other state.
- RUN: o_run_cnt increments by 1 each cycle and saturates at all-ones.
  - cmd_len!=0: RUN lasts exactly cmd_len cycles. Leave for STOP_WAIT on the cycle o_run_cnt becomes cmd_len, so the final o_run_cnt = cmd_len.
  - Accepted stop: go to STOP_WAIT next cycle; o_run_cnt stops at its current value.
  - Accepted start: consumed and ignored; mode is not changed.
  - Stop accepted on the same cycle the length expires: a single stop sequence.
- STOP_WAIT: o_stop=1, starting the first cycle in this state. Internal timeout counter starts at 0.
  - i_stop_ack=1: o_stop=0 next cycle; go to SETTLE.
  - STOP_TIMEOUT cycles without ack: set o_timeout_err, o_stop=0, go to SETTLE.
  - Ack on the same cycle the timeout expires: ack wins, no error.
- SETTLE: hold SETTLE_CYCLES cycles, then IDLE. o_mode keeps its value until the next start.
- i_stop_ack is ignored outside STOP_WAIT.
- err_clr clears o_timeout_err next cycle. If set and clear happen on the same cycle, set wins.
- Start-command-accept to o_start latency: 1 cycle.

Test Plan:
- Reset, start cmd mode=2 len=5 -> o_start high 1 cycle, 1 cycle after accept; o_mode=2; RUN 5 cycles; o_run_cnt=5; o_stop high until ack; SETTLE 16 cycles; IDLE.
- Start len=0, stop cmd after 100 RUN cycles -> o_run_cnt=100; o_stop asserted the next cycle; ack after 3 cycles -> o_stop low the cycle after ack; o_timeout_err=0.
- Start len=4, never ack -> o_stop high exactly 1024 cycles; o_timeout_err=1; SETTLE then IDLE. err_clr with no new error -> err=0. err_clr on the same cycle as a new timeout -> err stays 1.
- Ack on the exact timeout cycle -> no error; path to SETTLE is unchanged.
- Commands: stop cmd in IDLE -> no o_start/o_stop. Start cmd in RUN -> consumed, o_mode unchanged. cmd_valid held during STOP_WAIT/SETTLE -> cmd_ready=0 until IDLE, then accepted.
- rst asserted mid-STOP_WAIT with o_stop=1 -> next cycle o_stop=0, o_state=0, o_busy=0, o_run_cnt=0.
